// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: shares the video memory write port between
// host loader, draw engine and a range-clear sequencer.
module vram_write_arbiter #(
    parameter int unsigned              ADDR_W    = 16,
    parameter int unsigned              DATA_W    = 8,
    parameter logic [ADDR_W-1:0]        CLR_FIRST = '0,
    parameter logic [ADDR_W-1:0]        CLR_LAST  = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_data,
    output logic              h_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic              d_ack,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic RR_HOST = 1'b0;
    localparam logic RR_DRAW = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] clr_val_q, clr_val_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              h_ack_q, h_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;

    logic              h_elig;
    logic              d_elig;
    logic              grant_h;
    logic              grant_d;

    // A requester whose ack is high is still updating addr/data,
    // so it sits out this edge to avoid a duplicate write.
    always_comb begin
        h_elig  = h_req & ~h_ack_q;
        d_elig  = d_req & ~d_ack_q;
        grant_h = h_elig & (~d_elig | (rr_last_q == RR_DRAW));
        grant_d = d_elig & ~grant_h;
    end

    // Next-state: round-robin arbitration in IDLE, fill sweep in CLEAR.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        clr_val_d  = clr_val_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        h_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        clr_busy_d = clr_busy_q;
        clr_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    clr_val_d  = clr_value;
                    ptr_d      = CLR_FIRST;
                    last_d     = 1'b0;
                    state_d    = S_CLEAR;
                    clr_busy_d = 1'b1;
                end else if (grant_h) begin
                    mem_addr_d = h_addr;
                    mem_data_d = h_data;
                    mem_we_d   = 1'b1;
                    h_ack_d    = 1'b1;
                    rr_last_d  = RR_HOST;
                end else if (grant_d) begin
                    mem_addr_d = d_addr;
                    mem_data_d = d_data;
                    mem_we_d   = 1'b1;
                    d_ack_d    = 1'b1;
                    rr_last_d  = RR_DRAW;
                end
            end
            S_CLEAR: begin
                // Termination follows the compare against CLR_LAST,
                // so a sweep ending at all-ones is not fooled by the wrap.
                if (last_q) begin
                    state_d    = S_IDLE;
                    last_d     = 1'b0;
                    clr_busy_d = 1'b0;
                    clr_done_d = 1'b1;
                end else begin
                    mem_addr_d = ptr_q;
                    mem_data_d = clr_val_q;
                    mem_we_d   = 1'b1;
                    ptr_d      = ptr_q + 1'b1;
                    last_d     = (ptr_q == CLR_LAST);
                end
            end
        endcase
    end

    // State and registered outputs; reset also aborts a running clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_last_q  <= RR_DRAW;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            clr_val_q  <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            h_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            clr_val_q  <= clr_val_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            h_ack_q    <= h_ack_d;
            d_ack_q    <= d_ack_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        mem_addr = mem_addr_q;
        mem_data = mem_data_q;
        mem_we   = mem_we_q;
        h_ack    = h_ack_q;
        d_ack    = d_ack_q;
        clr_busy = clr_busy_q;
        clr_done = clr_done_q;
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: directed vectors for the vram write arbiter,
// table-driven arbitration plus hand sequences for clear corners.
module tb_vram_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_req, d_req, clr_start;
    logic [15:0] h_addr, d_addr;
    logic [7:0]  h_data, d_data, clr_value;
    logic        h_ack, d_ack, clr_busy, clr_done, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    logic        w_clr_start;
    logic [7:0]  w_clr_value;
    logic        w_h_ack, w_d_ack, w_busy, w_done, w_we;
    logic [15:0] w_addr;
    logic [7:0]  w_data;

    int n_vec = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    logic [7:0] mem [0:65535];

    vram_write_arbiter #(
        .ADDR_W(16), .DATA_W(8),
        .CLR_FIRST(16'h0000), .CLR_LAST(16'h000F)
    ) u_dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .h_ack(h_ack),
        .d_req(d_req), .d_addr(d_addr), .d_data(d_data), .d_ack(d_ack),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we)
    );

    vram_write_arbiter #(
        .ADDR_W(16), .DATA_W(8),
        .CLR_FIRST(16'hFFFC), .CLR_LAST(16'hFFFF)
    ) u_wrap (
        .clk(clk), .rst(rst),
        .h_req(1'b0), .h_addr(16'h0000), .h_data(8'h00), .h_ack(w_h_ack),
        .d_req(1'b0), .d_addr(16'h0000), .d_data(8'h00), .d_ack(w_d_ack),
        .clr_start(w_clr_start), .clr_value(w_clr_value),
        .clr_busy(w_busy), .clr_done(w_done),
        .mem_addr(w_addr), .mem_data(w_data), .mem_we(w_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_vec = n_vec + 1;
            if ((32'(h_ack) + 32'(d_ack) + 32'(clr_busy)) != 32'd1) begin
                n_bad = n_bad + 1;
                $display("FAIL we_owner: ack/busy sum %0d required 1",
                         32'(h_ack) + 32'(d_ack) + 32'(clr_busy));
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        h_req;
        logic [15:0] h_addr;
        logic [7:0]  h_data;
        logic        d_req;
        logic [15:0] d_addr;
        logic [7:0]  d_data;
        logic        e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_hack;
        logic        e_dack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r,
        input logic hr, input logic [15:0] ha, input logic [7:0] hd,
        input logic dr, input logic [15:0] da, input logic [7:0] dd,
        input logic ew, input logic [15:0] ea, input logic [7:0] ed,
        input logic eh, input logic edk
    );
        vec_t v;
        v.rst = r;
        v.h_req = hr; v.h_addr = ha; v.h_data = hd;
        v.d_req = dr; v.d_addr = da; v.d_data = dd;
        v.e_we = ew; v.e_addr = ea; v.e_data = ed;
        v.e_hack = eh; v.e_dack = edk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rst = 1'b0;
        h_req = 1'b0; h_addr = '0; h_data = '0;
        d_req = 1'b0; d_addr = '0; d_data = '0;
        clr_start = 1'b0; clr_value = '0;
        w_clr_start = 1'b0; w_clr_value = '0;
    endtask

    initial begin
        vec_t v;
        logic quiet;

        // reset, single host write, idle
        tbl.push_back(mk(1, 0,16'h0,8'h0,   0,16'h0,8'h0,   0,16'h0,8'h0,    0,0));
        tbl.push_back(mk(0, 1,16'h2000,8'hA5, 0,16'h0,8'h0, 1,16'h2000,8'hA5, 1,0));
        tbl.push_back(mk(0, 0,16'h0,8'h0,   0,16'h0,8'h0,   0,16'h0,8'h0,    0,0));
        // reset, then both held: H first, then alternate
        tbl.push_back(mk(1, 0,16'h0,8'h0,   0,16'h0,8'h0,   0,16'h0,8'h0,    0,0));
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                tbl.push_back(mk(0, 1,16'h0010,8'h11, 1,16'h0020,8'h22,
                                 1,16'h0010,8'h11, 1,0));
            else
                tbl.push_back(mk(0, 1,16'h0010,8'h11, 1,16'h0020,8'h22,
                                 1,16'h0020,8'h22, 0,1));
        end
        tbl.push_back(mk(0, 0,16'h0,8'h0,   0,16'h0,8'h0,   0,16'h0,8'h0,    0,0));
        // draw only, address advanced on each ack
        tbl.push_back(mk(0, 0,16'h0,8'h0, 1,16'h0030,8'h30, 1,16'h0030,8'h30, 0,1));
        tbl.push_back(mk(0, 0,16'h0,8'h0, 1,16'h0031,8'h31, 0,16'h0,8'h0,     0,0));
        tbl.push_back(mk(0, 0,16'h0,8'h0, 1,16'h0031,8'h31, 1,16'h0031,8'h31, 0,1));
        tbl.push_back(mk(0, 0,16'h0,8'h0, 1,16'h0032,8'h32, 0,16'h0,8'h0,     0,0));
        tbl.push_back(mk(0, 0,16'h0,8'h0, 1,16'h0032,8'h32, 1,16'h0032,8'h32, 0,1));
        tbl.push_back(mk(0, 0,16'h0,8'h0, 1,16'h0033,8'h33, 0,16'h0,8'h0,     0,0));
        tbl.push_back(mk(0, 0,16'h0,8'h0, 1,16'h0033,8'h33, 1,16'h0033,8'h33, 0,1));
        tbl.push_back(mk(0, 0,16'h0,8'h0, 0,16'h0,8'h0,     0,16'h0,8'h0,     0,0));

        idle_inputs();
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rst = v.rst;
            h_req = v.h_req; h_addr = v.h_addr; h_data = v.h_data;
            d_req = v.d_req; d_addr = v.d_addr; d_data = v.d_data;
            tick();
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(v.e_we));
            chk($sformatf("v%0d_hack", i), 32'(h_ack), 32'(v.e_hack));
            chk($sformatf("v%0d_dack", i), 32'(d_ack), 32'(v.e_dack));
            chk($sformatf("v%0d_busy", i), 32'(clr_busy), 32'd0);
            chk($sformatf("v%0d_done", i), 32'(clr_done), 32'd0);
            if (v.e_we || v.rst) begin
                chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(v.e_addr));
                chk($sformatf("v%0d_data", i), 32'(mem_data), 32'(v.e_data));
            end
        end
        tick();
        chk("rd_2000", 32'(mem[16'h2000]), 32'h A5);
        chk("rd_0010", 32'(mem[16'h0010]), 32'h11);
        chk("rd_0020", 32'(mem[16'h0020]), 32'h22);
        for (int a = 0; a < 4; a++)
            chk($sformatf("rd_%0h", 16'h30 + a),
                32'(mem[16'h0030 + 16'(a)]), 32'h30 + 32'(a));
        chk("tbl_wr_cnt", 32'(wr_cnt), 32'd13);

        // clear with host pending; second clr_start mid-clear ignored
        rst = 1'b1; tick(); rst = 1'b0;
        h_req = 1'b1; h_addr = 16'h0040; h_data = 8'h77;
        clr_start = 1'b1; clr_value = 8'h3C;
        tick();
        chk("c4_busy0", 32'(clr_busy), 32'd1);
        chk("c4_we0", 32'(mem_we), 32'd0);
        chk("c4_hack0", 32'(h_ack), 32'd0);
        clr_start = 1'b0; clr_value = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                clr_start = 1'b1; clr_value = 8'hFF;
            end
            tick();
            clr_start = 1'b0;
            chk($sformatf("c4_we%0d", i), 32'(mem_we), 32'd1);
            chk($sformatf("c4_addr%0d", i), 32'(mem_addr), 32'(i));
            chk($sformatf("c4_data%0d", i), 32'(mem_data), 32'h3C);
            chk($sformatf("c4_hack%0d", i), 32'(h_ack), 32'd0);
            chk($sformatf("c4_done%0d", i), 32'(clr_done), 32'd0);
            chk($sformatf("c4_busy%0d", i), 32'(clr_busy), 32'd1);
        end
        tick();
        chk("c4_done", 32'(clr_done), 32'd1);
        chk("c4_done_we", 32'(mem_we), 32'd0);
        chk("c4_done_busy", 32'(clr_busy), 32'd0);
        chk("c4_done_hack", 32'(h_ack), 32'd0);
        tick();
        chk("c4_h_hack", 32'(h_ack), 32'd1);
        chk("c4_h_addr", 32'(mem_addr), 32'h0040);
        chk("c4_h_data", 32'(mem_data), 32'h77);
        chk("c4_h_done", 32'(clr_done), 32'd0);
        h_req = 1'b0;
        tick();
        for (int a = 0; a < 16; a++)
            chk($sformatf("c4_rd%0d", a), 32'(mem[16'(a)]), 32'h3C);
        chk("c4_rd40", 32'(mem[16'h0040]), 32'h77);

        // clr_start together with d_req: clear wins, draw waits
        d_req = 1'b1; d_addr = 16'h0050; d_data = 8'h55;
        clr_start = 1'b1; clr_value = 8'hC3;
        tick();
        clr_start = 1'b0;
        chk("c5_busy", 32'(clr_busy), 32'd1);
        chk("c5_dack0", 32'(d_ack), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("c5_dack%0d", i), 32'(d_ack), 32'd0);
            chk($sformatf("c5_addr%0d", i), 32'(mem_addr), 32'(i));
        end
        tick();
        chk("c5_done", 32'(clr_done), 32'd1);
        chk("c5_done_dack", 32'(d_ack), 32'd0);
        tick();
        chk("c5_dack", 32'(d_ack), 32'd1);
        chk("c5_d_addr", 32'(mem_addr), 32'h0050);
        chk("c5_d_data", 32'(mem_data), 32'h55);
        d_req = 1'b0;
        tick();

        // reset at the 5th clear write aborts with no done
        clr_start = 1'b1; clr_value = 8'h5A;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("c6_addr%0d", i), 32'(mem_addr), 32'(i));
        end
        rst = 1'b1; clr_start = 1'b1; clr_value = 8'h99;
        tick();
        rst = 1'b0; clr_start = 1'b0;
        chk("c6_rst_we", 32'(mem_we), 32'd0);
        chk("c6_rst_addr", 32'(mem_addr), 32'd0);
        chk("c6_rst_data", 32'(mem_data), 32'd0);
        chk("c6_rst_hack", 32'(h_ack), 32'd0);
        chk("c6_rst_dack", 32'(d_ack), 32'd0);
        chk("c6_rst_busy", 32'(clr_busy), 32'd0);
        chk("c6_rst_done", 32'(clr_done), 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_done !== 1'b0 || clr_busy !== 1'b0 || mem_we !== 1'b0)
                quiet = 1'b0;
        end
        chk("c6_quiet", 32'(quiet), 32'd1);
        for (int a = 0; a < 4; a++)
            chk($sformatf("c6_rd%0d", a), 32'(mem[16'(a)]), 32'h5A);
        chk("c6_rd4", 32'(mem[16'h0004]), 32'hC3);
        clr_start = 1'b1; clr_value = 8'h11;
        tick();
        clr_start = 1'b0;
        tick();
        chk("c6_re_addr", 32'(mem_addr), 32'h0000);
        chk("c6_re_data", 32'(mem_data), 32'h11);
        chk("c6_re_we", 32'(mem_we), 32'd1);
        repeat (15) tick();
        chk("c6_re_last", 32'(mem_addr), 32'h000F);
        tick();
        chk("c6_re_done", 32'(clr_done), 32'd1);

        // clear ending at all-ones must stop on compare, not wrap
        w_clr_start = 1'b1; w_clr_value = 8'hE7;
        tick();
        w_clr_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("w_we%0d", i), 32'(w_we), 32'd1);
            chk($sformatf("w_addr%0d", i), 32'(w_addr), 32'hFFFC + 32'(i));
            chk($sformatf("w_data%0d", i), 32'(w_data), 32'hE7);
        end
        tick();
        chk("w_done", 32'(w_done), 32'd1);
        chk("w_done_we", 32'(w_we), 32'd0);
        chk("w_done_busy", 32'(w_busy), 32'd0);
        tick();
        chk("w_after_we", 32'(w_we), 32'd0);
        chk("w_after_done", 32'(w_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
